// File: rtl/seq_divider16_if.sv
// Handshake and result bundle for the sequential divider.
// The requester drives start/operands; the divider returns status and results.
interface seq_divider16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// built as a two's-complement add whose carry-out decides keep or restore.
module seq_divider16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  seq_divider16_if.slave    bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] d_r, d_s;
  logic [WIDTH:0]   rem_r, rem_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] quotient_r, quotient_s;
  logic [WIDTH-1:0] remainder_r, remainder_s;
  logic             dbz_r, dbz_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;

  // S + ~{0,D} + 1; bit WIDTH+1 is the carry-out, set exactly when S >= D
  function automatic logic [WIDTH+1:0] trial_sub(input logic [WIDTH:0] s,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH:0] d_inv;
    d_inv = ~{1'b0, d};
    return {1'b0, s} + {1'b0, d_inv} + {{(WIDTH+1){1'b0}}, 1'b1};
  endfunction

  // Next-state, datapath step and result capture
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    d_s         = d_r;
    rem_s       = rem_r;
    cnt_s       = cnt_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    quotient_s  = quotient_r;
    remainder_s = remainder_r;
    dbz_s       = dbz_r;
    shifted_s   = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
    trial_s     = trial_sub(shifted_s, d_r);
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (bus.start) begin
          q_s   = bus.dividend;
          d_s   = bus.divisor;
          rem_s = {(WIDTH+1){1'b0}};
          cnt_s = {CNT_W{1'b0}};
          if (bus.divisor != {WIDTH{1'b0}}) begin
            state_s = RUN;
            busy_s  = 1'b1;
          end else begin
            state_s     = DONE;
            done_s      = 1'b1;
            quotient_s  = {WIDTH{1'b1}};
            remainder_s = bus.dividend;
            dbz_s       = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (trial_s[WIDTH+1]) begin
          rem_s = trial_s[WIDTH:0];
          q_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
          rem_s = shifted_s;
          q_s   = {q_r[WIDTH-2:0], 1'b0};
        end
        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_W'(WIDTH-1)) begin
          state_s     = DONE;
          busy_s      = 1'b0;
          done_s      = 1'b1;
          quotient_s  = q_s;
          remainder_s = rem_s[WIDTH-1:0];
          dbz_s       = 1'b0;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      q_r         <= {WIDTH{1'b0}};
      d_r         <= {WIDTH{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      q_r         <= q_s;
      d_r         <= d_s;
      rem_r       <= rem_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      quotient_r  <= quotient_s;
      remainder_r <= remainder_s;
      dbz_r       <= dbz_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider16.sv
// Scoreboard bench for seq_divider16: expected results are queued at start
// and popped when done is seen.
module tb_seq_divider16;
  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  seq_divider16_if #(.WIDTH(16)) bus ();

  seq_divider16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_div(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Pulse start for one edge, then wait (bounded) for done
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic z, output int lat,
                        output bit busy_seen, output bit timed_out);
    @(posedge clk); #1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 16'($urandom);
    lat = 0;
    busy_seen = 1'b0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    timed_out = (bus.done !== 1'b1);
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'd0 ||
        bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: busy=%b done=%b q=%h r=%h z=%b, expected all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    logic [15:0] q, r;
    logic z;
    int lat;
    bit bs, to;
    exp_t e;
    sb.push_back(ref_div(16'd100, 16'd7));
    run_op(16'd100, 16'd7, q, r, z, lat, bs, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || q !== e.q || r !== e.r || z !== e.z) begin
      n_err++;
      $display("FAIL normal_result: got q=%0d r=%0d z=%b to=%b, expected q=%0d r=%0d z=%b",
               q, r, z, to, e.q, e.r, e.z);
    end
    n_cmp++;
    if (lat !== 16) begin
      n_err++;
      $display("FAIL normal_latency: got %0d edges after start, expected 16", lat);
    end
    n_cmp++;
    if (bs !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL normal_busy: busy_seen=%b busy_at_done=%b, expected 1 and 0", bs, bus.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
      n_err++;
      $display("FAIL normal_hold: done=%b q=%0d r=%0d, expected done=0 q=14 r=2",
               bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] as[3];
    logic [15:0] bs_[3];
    logic [15:0] q, r;
    logic z;
    int lat;
    bit bs, to;
    exp_t e;
    as  = '{16'hFFFF, 16'hFFFF, 16'd3};
    bs_ = '{16'd1, 16'hFFFF, 16'd10};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ref_div(as[i], bs_[i]));
      run_op(as[i], bs_[i], q, r, z, lat, bs, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || q !== e.q || r !== e.r || z !== e.z || lat !== 16) begin
        n_err++;
        $display("FAIL boundary_%0d: %h/%h got q=%h r=%h z=%b lat=%0d, expected q=%h r=%h z=0 lat=16",
                 i, as[i], bs_[i], q, r, z, lat, e.q, e.r);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q, r;
    logic z;
    int lat;
    bit bs, to;
    exp_t e;
    sb.push_back(ref_div(16'd5, 16'd0));
    run_op(16'd5, 16'd0, q, r, z, lat, bs, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || q !== e.q || r !== e.r || z !== e.z) begin
      n_err++;
      $display("FAIL dbz_result: got q=%h r=%0d z=%b, expected q=%h r=%0d z=%b",
               q, r, z, e.q, e.r, e.z);
    end
    n_cmp++;
    if (lat !== 0 || bs !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL dbz_timing: lat=%0d busy_seen=%b, expected lat=0 busy never 1", lat, bs);
    end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] q, r;
    logic z;
    int lat;
    bit bs, to;
    exp_t e;
    @(posedge clk); #1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd3;
    bus.start    = 1'b1;
    sb.push_back(ref_div(16'd1000, 16'd3));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.dividend = 16'd9;
    bus.divisor  = 16'd9;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 5;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.quotient !== e.q || bus.remainder !== e.r || lat !== 16) begin
      n_err++;
      $display("FAIL busy_ignore: got q=%0d r=%0d lat=%0d, expected q=%0d r=%0d lat=16",
               bus.quotient, bus.remainder, lat, e.q, e.r);
    end
    sb.push_back(ref_div(16'd9, 16'd9));
    run_op(16'd9, 16'd9, q, r, z, lat, bs, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || q !== e.q || r !== e.r || z !== e.z) begin
      n_err++;
      $display("FAIL busy_followup: got q=%0d r=%0d, expected q=%0d r=%0d", q, r, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] q, r;
    logic z;
    int lat;
    bit bs, to, saw_done;
    exp_t e;
    @(posedge clk); #1;
    bus.dividend = 16'd50000;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    sb.push_back(ref_div(16'd50000, 16'd7));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'd0 ||
        bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: busy=%b done=%b q=%h r=%h z=%b, expected all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_discard: saw busy/done after reset=%b, expected 0", saw_done);
    end
    sb.push_back(ref_div(16'd50, 16'd5));
    run_op(16'd50, 16'd5, q, r, z, lat, bs, to);
    e = sb.pop_front();
    n_cmp++;
    if (to || q !== e.q || r !== e.r || z !== e.z) begin
      n_err++;
      $display("FAIL midrun_after: got q=%0d r=%0d, expected q=%0d r=%0d", q, r, e.q, e.r);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, q, r;
    logic z;
    int lat;
    bit bs, to;
    exp_t e;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(65535, 1));
      if (i % 4 == 0) b = 16'($urandom_range(255, 1));
      sb.push_back(ref_div(a, b));
      run_op(a, b, q, r, z, lat, bs, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || q !== e.q || r !== e.r || z !== 1'b0 ||
          (32'(q) * 32'(b) + 32'(r)) !== 32'(a) || r >= b) begin
        n_err++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d z=%b, expected q=%0d r=%0d z=0",
                 i, a, b, q, r, z, e.q, e.r);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_normal();
    test_boundary();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_divider16.md
Name: seq_divider16

Overview:
Multi-cycle unsigned restoring divider. It is the inverse of the ripple add/subtract datapath: each iteration performs one trial subtraction, implemented as a two's-complement add, and either keeps or discards the result. The block sits beside the 16-bit adder/subtractor in the arithmetic unit. It accepts one operation through a start/done handshake and returns quotient, remainder and a divide-by-zero flag.

Parameters:
WIDTH, 16, operand/quotient/remainder width in bits
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
dividend  input  WIDTH  numerator, unsigned; sampled on the start edge
divisor  input  WIDTH  denominator, unsigned; sampled on the start edge
busy  output  1  high while an operation is in RUN
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  result quotient, held until the next accepted start
remainder  output  WIDTH  result remainder, held until the next accepted start
div_by_zero  output  1  set with done when the latched divisor == 0; held with the results

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal partial remainder (WIDTH+1 bits)=0. Reset takes effect immediately, including mid-RUN; the in-flight operation is discarded and no done is produced.
- States:
  - IDLE: start=1 at edge T latches dividend into the Q shift register and divisor into D, and clears R and the counter.
    - If divisor != 0: go to RUN; busy=1 from T+1.
    - If divisor == 0: go to DONE at T+1 with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, busy stays 0.
  - RUN: one restoring step per edge.
    - Form S = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
    - Form T = S + ~{0,D} + 1 (adder with sub=1, carry-in=1).
    - If the carry-out is 1 (S >= D): R <= T and shift 1 into Q.
    - Otherwise: R <= S and shift 0 into Q.
    - Q shifts left each step.
    - Counter increments. On the step where counter == WIDTH-1, go to DONE.
  - DONE: lasts exactly one cycle.
    - done=1, busy=0.
    - quotient=Q and remainder=R[WIDTH-1:0]; div_by_zero=0 for a normal operation.
    - Next edge returns to IDLE with done=0.
- Latency: for a nonzero divisor, start at edge T gives done high during the cycle after edge T+WIDTH (T+16 by default). Total start-to-done is WIDTH+1 cycles. For divisor==0, done is high in the cycle after edge T.
- Handshake:
  - start is ignored in RUN and DONE; there is no queueing.
  - The earliest next accepted start is the first IDLE cycle after done.
  - dividend and divisor may change freely after the start edge.
- Arithmetic: unsigned only. R never exceeds D-1 after a step. The WIDTH+1 intermediate bit prevents loss when R[WIDTH-1]=1.
- Outputs are held stable from done until the next accepted start. They are not cleared when the FSM returns to IDLE.

Test Plan:
- Normal divide: reset, then dividend=100, divisor=7, start at T -> busy 1 over T+1..T+16, done in the cycle after T+16, quotient=14, remainder=2, div_by_zero=0.
- Boundary values:
  - 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
  - 0xFFFF/0xFFFF -> quotient=1, remainder=0.
  - 3/10 -> quotient=0, remainder=3.
- Divide by zero: dividend=5, divisor=0 -> done one cycle after start, quotient=0xFFFF, remainder=5, div_by_zero=1, busy never high.
- Start while busy: start 1000/3, then pulse start with 9/9 at T+5 -> ignored; result quotient=333, remainder=1. The next start after done runs 9/9 -> quotient=1, remainder=0.
- Reset mid-operation: assert rst asynchronously between edges during RUN at T+8 -> busy, done, quotient, remainder, div_by_zero go to 0 immediately. After release, 50/5 -> quotient=10, remainder=0.
- Random sweep: 1000 random pairs with nonzero divisor, checked against a reference model -> quotient*divisor + remainder == dividend and remainder < divisor for every result.
